// File: rtl/riscv_defines.sv
// riscv_defines: shared constants and types for the interrupt arbiter slice.
package riscv_defines;

    localparam int unsigned              IRQ_ID_WIDTH = 5;
    localparam logic [IRQ_ID_WIDTH-1:0]  IRQ_NMI_ID   = 5'd31;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_CLR
    } irq_arb_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// riscv_irq_prio_enc: combinational fixed-priority encoder over 32 eligible
// lines. The NMI line beats everything; otherwise the highest index wins.
module riscv_irq_prio_enc
    import riscv_defines::*;
(
    input  logic [31:0]             eligible_i,
    input  logic [IRQ_ID_WIDTH-1:0] nmi_id_i,
    output logic                    valid_o,
    output logic [IRQ_ID_WIDTH-1:0] id_o
);

    // Ascending scan so the last (highest) eligible index is kept, then NMI override.
    always_comb begin
        valid_o = |eligible_i;
        id_o    = '0;
        for (int i = 0; i < 32; i++) begin
            if (eligible_i[i]) id_o = IRQ_ID_WIDTH'(i);
        end
        if (eligible_i[nmi_id_i]) id_o = nmi_id_i;
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// riscv_irq_arbiter: collects raw interrupt lines, keeps edge lines pending
// until acknowledged, masks by enable (NMI exempt) and issues one stable
// request at a time towards the core interrupt controller.
// Optional build macro RISCV_IRQ_ARB_SYNC_EN inserts a 2-flop synchronizer
// on irq_lines_i (line-to-request latency 3 cycles instead of 1).
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned             NUM_IRQ   = 32,
    parameter logic [31:0]             EDGE_MASK = 32'hFFFF_0000,
    parameter logic [IRQ_ID_WIDTH-1:0] NMI_ID    = IRQ_NMI_ID
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IRQ-1:0]      irq_lines_i,
    input  logic [NUM_IRQ-1:0]      irq_en_i,
    input  logic [NUM_IRQ-1:0]      irq_sec_lines_i,
    output logic                    irq_o,
    output logic [IRQ_ID_WIDTH-1:0] irq_id_o,
    output logic                    irq_sec_o,
    input  logic                    irq_ack_i,
    input  logic [IRQ_ID_WIDTH-1:0] irq_ack_id_i,
    output logic [NUM_IRQ-1:0]      irq_pending_o
);

    localparam logic [NUM_IRQ-1:0] EDGE_M = EDGE_MASK[NUM_IRQ-1:0];

    logic [NUM_IRQ-1:0]      lines_s;
    logic [NUM_IRQ-1:0]      hist_q;
    logic [NUM_IRQ-1:0]      pend_edge_q;
    logic [NUM_IRQ-1:0]      pend_edge_d;
    logic [NUM_IRQ-1:0]      rise;
    logic [NUM_IRQ-1:0]      pending;
    logic [NUM_IRQ-1:0]      nmi_mask;
    logic [NUM_IRQ-1:0]      ack_clr;
    logic [31:0]             elig_full;
    logic [31:0]             sec_full;
    logic                    ack_hit;
    logic                    win_vld;
    logic [IRQ_ID_WIDTH-1:0] win_id;
    logic [IRQ_ID_WIDTH-1:0] id_q;
    logic                    sec_q;
    logic                    irq_q;
    irq_arb_state_e          state_q;

`ifdef RISCV_IRQ_ARB_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;

    // Two-stage synchronizer for asynchronous peripheral lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_lines_i;
            sync2_q <= sync1_q;
        end
    end

    assign lines_s = sync2_q;
`else
    assign lines_s = irq_lines_i;
`endif

    // A fresh rising edge counts as pending in the same cycle so edge and
    // level lines share the same request latency.
    assign rise        = lines_s & ~hist_q & EDGE_M;
    assign pending     = (pend_edge_q & EDGE_M) | rise | (lines_s & ~EDGE_M);
    assign pend_edge_d = (pend_edge_q & ~ack_clr) | rise;
    assign ack_hit     = (state_q == ARB_REQ) && irq_ack_i && (irq_ack_id_i == id_q);

    // Per-line NMI exemption and the one-hot clear produced by a matching ack.
    always_comb begin
        nmi_mask = '0;
        ack_clr  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (NMI_ID == IRQ_ID_WIDTH'(i)) nmi_mask[i] = 1'b1;
            if (ack_hit && (id_q == IRQ_ID_WIDTH'(i))) ack_clr[i] = 1'b1;
        end
    end

    // Widen to the full ID space; unused IDs stay zero and can never win.
    always_comb begin
        elig_full                = '0;
        sec_full                 = '0;
        elig_full[NUM_IRQ-1:0]   = pending & (irq_en_i | nmi_mask);
        sec_full[NUM_IRQ-1:0]    = irq_sec_lines_i;
    end

    riscv_irq_prio_enc u_prio_enc (
        .eligible_i (elig_full),
        .nmi_id_i   (NMI_ID),
        .valid_o    (win_vld),
        .id_o       (win_id)
    );

    // Edge-detect history and sticky edge pending bits (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            pend_edge_q <= '0;
        end else begin
            hist_q      <= lines_s;
            pend_edge_q <= pend_edge_d;
        end
    end

    // Request FSM: latch a winner, hold it until ack or withdraw, then a
    // one-cycle gap so a level source can drop before re-arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
            sec_q   <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win_vld) begin
                        id_q    <= win_id;
                        sec_q   <= sec_full[win_id];
                        irq_q   <= 1'b1;
                        state_q <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (ack_hit) begin
                        irq_q   <= 1'b0;
                        state_q <= ARB_CLR;
                    end else if (!elig_full[id_q]) begin
                        irq_q   <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_CLR: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign irq_o         = irq_q;
    assign irq_id_o      = id_q;
    assign irq_sec_o     = sec_q;
    assign irq_pending_o = pending;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// tb_riscv_irq_arbiter: directed scenarios plus randomized traffic, checked
// against a behavioural model through an expected-response queue.
module tb_riscv_irq_arbiter;

`ifdef RISCV_IRQ_ARB_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam logic [31:0] EDGE = 32'hFFFF_0000;
    localparam int          NMI  = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lines = '0;
    logic [31:0] en = '0;
    logic [31:0] sec = '0;
    logic        ack = 1'b0;
    logic [4:0]  ack_id = '0;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_sec_o;
    logic [31:0] pend_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        irq;
        logic [4:0]  id;
        logic        sec;
        logic [31:0] pend;
    } exp_t;
    exp_t sb[$];

    // Reference model state: an outstanding request (busy), a one-cycle
    // cool-down after an ack, sticky edge flags and the line history.
    bit          m_busy, m_cool, m_sec;
    int          m_id;
    logic [31:0] m_pend_e, m_prev, m_s1, m_s2;

    riscv_irq_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_lines_i     (lines),
        .irq_en_i        (en),
        .irq_sec_lines_i (sec),
        .irq_o           (irq_o),
        .irq_id_o        (irq_id_o),
        .irq_sec_o       (irq_sec_o),
        .irq_ack_i       (ack),
        .irq_ack_id_i    (ack_id),
        .irq_pending_o   (pend_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", n, $time, got, exp);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_cool = 0; m_sec = 0; m_id = 0;
        m_pend_e = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    endfunction

    // Pending view as seen from the current line values and history.
    function automatic logic [31:0] view();
        logic [31:0] seen;
        seen = SYNC ? m_s2 : lines;
        return ((m_pend_e | (seen & ~m_prev)) & EDGE) | (seen & ~EDGE);
    endfunction

    // NMI first if eligible, otherwise the highest eligible index.
    function automatic int pick(logic [31:0] elig);
        if (elig[NMI]) return NMI;
        for (int i = 31; i >= 0; i--) if (elig[i]) return i;
        return -1;
    endfunction

    function automatic void model_step();
        logic [31:0] seen, elig;
        bit          hit;
        int          w;
        seen = SYNC ? m_s2 : lines;
        elig = view() & (en | (32'h1 << NMI));
        hit  = m_busy && ack && (int'(ack_id) == m_id);
        if (m_cool) begin
            m_cool = 0;
        end else if (m_busy) begin
            if (hit) begin
                m_busy = 0;
                m_cool = 1;
            end else if (!elig[m_id]) begin
                m_busy = 0;
            end
        end else begin
            w = pick(elig);
            if (w >= 0) begin
                m_busy = 1;
                m_id   = w;
                m_sec  = sec[w];
            end
        end
        if (hit) m_pend_e[m_id] = 1'b0;
        m_pend_e = m_pend_e | (EDGE & seen & ~m_prev);
        m_prev = seen;
        m_s2   = m_s1;
        m_s1   = lines;
    endfunction

    function automatic void push_model();
        exp_t e;
        e.irq  = m_busy;
        e.id   = 5'(m_id);
        e.sec  = m_sec;
        e.pend = view();
        sb.push_back(e);
    endfunction

    function automatic void push_zero();
        exp_t e;
        e.irq = 1'b0; e.id = '0; e.sec = 1'b0; e.pend = '0;
        sb.push_back(e);
    endfunction

    // Monitor: compare whatever the DUT shows mid-cycle with the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("irq_o", 32'(irq_o), 32'(e.irq));
            chk("irq_id_o", 32'(irq_id_o), 32'(e.id));
            chk("irq_sec_o", 32'(irq_sec_o), 32'(e.sec));
            chk("irq_pending_o", pend_o, e.pend);
        end
    end

    // One clock with the current inputs; a one-shot ack is dropped afterwards.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            push_model();
            @(negedge clk);
            #1;
            ack = 1'b0;
        end
    endtask

    task automatic do_ack(input int id);
        ack    = 1'b1;
        ack_id = 5'(id);
        step(1);
    endtask

    // Reset asserted in the middle of a cycle, outputs must clear before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        model_reset();
        push_zero();
        #2;
        rst_n = 1'b0;
        lines = '0;
        ack   = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            push_zero();
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            push_zero();
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
        en    = '1;

        // Level line 11, a mismatched ack, a real ack, re-request, then drop.
        lines = 32'h1 << 11;
        step(4);
        do_ack(12);
        step(1);
        do_ack(11);
        step(4);
        lines = '0;
        step(4);

        // Edge lines 16 and 20 together; 25 arrives while 16 is held.
        lines = (32'h1 << 16) | (32'h1 << 20);
        step(1);
        lines = '0;
        step(4);
        do_ack(20);
        step(4);
        lines = 32'h1 << 25;
        step(1);
        lines = '0;
        step(3);
        do_ack(16);
        step(5);
        do_ack(25);
        step(3);

        // Level line 3 withdrawn before ack.
        lines = 32'h1 << 3;
        step(4);
        lines = '0;
        step(4);

        // NMI ignores its disabled enable and beats line 30.
        en    = 32'h1 << 30;
        lines = 32'hC000_0000;
        step(1);
        lines = '0;
        step(4);
        do_ack(31);
        step(5);
        do_ack(30);
        step(3);

        // Secure line 7 held in REQ, then reset mid-request.
        en    = '1;
        sec   = 32'h1 << 7;
        lines = 32'h1 << 7;
        step(4);
        mid_reset();
        sec = '0;
        step(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            lines = $urandom & $urandom & $urandom;
            en    = $urandom | $urandom;
            sec   = $urandom;
            if (m_busy && ($urandom_range(0, 2) == 0)) begin
                ack    = 1'b1;
                ack_id = 5'(m_id);
            end else if ($urandom_range(0, 7) == 0) begin
                ack    = 1'b1;
                ack_id = 5'($urandom);
            end
            step(1);
        end

        lines = '0;
        step(3);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_irq_arbiter.md
Name: riscv_irq_arbiter

Overview:
- Upstream stage of the core interrupt controller; it drives that controller's irq_i / irq_id_i / irq_sec_i inputs.
- Collects 32 raw interrupt lines and latches edge-type lines into pending bits.
- Applies enable and secure masks, selects one winner by fixed priority, and holds a stable request until the core acknowledges or the request becomes invalid.
- Exposes the pending vector for the mip CSR view.

Parameters:
- NUM_IRQ, 32, number of interrupt lines; legal range 2..32; ID width fixed at 5.
- EDGE_MASK, 32'hFFFF_0000, bit i = 1 makes line i edge-triggered (rising); 0 makes it level-triggered.
- NMI_ID, 31, line that ignores irq_en_i and is always highest priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- irq_lines_i  in  NUM_IRQ  raw interrupt lines from peripherals/event unit
- irq_en_i  in  NUM_IRQ  per-line enable (mie)
- irq_sec_lines_i  in  NUM_IRQ  per-line secure attribute
- irq_o  out  1  request to interrupt controller (its irq_i)
- irq_id_o  out  5  winning ID (its irq_id_i)
- irq_sec_o  out  1  secure bit of the winner (its irq_sec_i)
- irq_ack_i  in  1  core took interrupt irq_ack_id_i
- irq_ack_id_i  in  5  ID being acknowledged
- irq_pending_o  out  NUM_IRQ  pending vector (mip view)

Behaviour:
- Reset: irq_o=0, irq_id_o=0, irq_sec_o=0, irq_pending_o=0; edge-detect history=0; state IDLE. Reset is honoured mid-request; the request is dropped and nothing is replayed.
- Pending:
  - Level line: pending[i] = synced line[i], combinational from the registered or synced input.
  - Edge line: pending[i] is set on a 0->1 transition of the line and stays set until cleared by an ack with that ID.
  - When set and clear coincide on the same cycle, set wins; a new edge is never lost.
- Eligible: pend[i] & (irq_en_i[i] | i==NMI_ID).
- Priority: NMI_ID first, then highest index wins. The winner is computed by the combinational priority encoder.
- FSM:
  - IDLE: if any line is eligible, register the winner into id_q/sec_q, assert irq_o next cycle, and go to REQ. Latency is 1 cycle from the pending bit to irq_o.
  - REQ: irq_o=1; irq_id_o/irq_sec_o are held stable even if a higher-priority line arrives (no pre-emption of an issued request).
    - irq_ack_i & irq_ack_id_i==id_q: clear the edge pending bit for that ID, go to CLR.
    - If the held line is no longer eligible (level line dropped, or enable cleared): deassert irq_o and go to IDLE. This is a withdraw, and the controller treats it as a kill.
    - Ack and withdraw in the same cycle: ack wins.
  - CLR: irq_o=0 for exactly one cycle so that a level source can drop; then go to IDLE.
- An ack with a mismatched ID is ignored; an ack outside REQ is ignored.
- irq_sec_o is irq_sec_lines_i[winner], sampled at selection and held.
- When NUM_IRQ<32, unused IDs are never selected.

Optional Feature:
- Macro RISCV_IRQ_ARB_SYNC_EN.
- Defined: irq_lines_i passes through a 2-flop synchronizer (reset 0) before edge detection and pending. Latency from line to irq_o is 3 cycles.
- Undefined: lines are used directly, with 1-cycle latency; the edge-detect history flop is still present.

Decomposition:
- riscv_defines gets IRQ_NMI_ID=5'd31, IRQ_ID_WIDTH=5, and the enum irq_arb_state_e {ARB_IDLE, ARB_REQ, ARB_CLR}.
- One sub-module, riscv_irq_prio_enc: combinational; inputs eligible vector and NMI_ID; outputs valid and 5-bit ID.

Test Plan:
- Single level line 11 high, irq_en_i[11]=1 -> irq_o=1, irq_id_o=11 one cycle later; ack id 11 -> irq_o low for one CLR cycle; with line still high, re-request id 11 in the following cycle.
- Edge lines 16 and 20 pulse on the same cycle, both enabled -> id 20 first; ack 20 -> CLR then id 16; pending[16] clears only after ack 16.
- While in REQ with id 16, raise line 25 -> irq_id_o stays 16 until ack, then 25 is issued.
- Level line 3 requested, line drops before ack -> irq_o falls the next cycle with no ack needed; pending_o[3]=0.
- Line 31 asserted with irq_en_i=0 and line 30 enabled -> id 31 wins.
- irq_sec_lines_i[7]=1 -> irq_sec_o=1 while id 7 is requested.
- Assert rst_n low during REQ -> all outputs 0 immediately.
- With RISCV_IRQ_ARB_SYNC_EN defined -> 3-cycle latency on every scenario above.
